// File: rtl/debounce_pkg.sv
// Shared types and defaults for the level debouncer / edge detector.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } debounce_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/debounce_edge.sv
// Debounces a synchronized mechanical level, emitting one-cycle rise/fall
// strobes and an 8-bit wrapping count of accepted presses.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_sync,
  output logic       out_level,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] press_count
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  debounce_state_t       state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic [7:0]            count_q, count_d;

  // Strobes default low so each accepted change produces exactly one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE_LOW: begin
        if (in_sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!in_sync) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!in_sync) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (in_sync) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // A corrupted state register falls back to a clean, fully cleared state.
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
        count_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign out_level   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: default-parameter instance driven from a
// vector table, plus a DEBOUNCE_CYCLES=2 instance for the minimum setting.
module tb_debounce_edge;

  typedef struct {
    logic       in_val;
    logic       exp_level;
    logic       exp_rise;
    logic       exp_fall;
    logic [7:0] exp_count;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in1, in2;
  logic       level1, rise1, fall1;
  logic       level2, rise2, fall2;
  logic [7:0] count1, count2;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  vec_t vecs[$];

  debounce_edge dut1 (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_sync     (in1),
    .out_level   (level1),
    .rise_pulse  (rise1),
    .fall_pulse  (fall1),
    .press_count (count1)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(2)) dut2 (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_sync     (in2),
    .out_level   (level2),
    .rise_pulse  (rise2),
    .fall_pulse  (fall2),
    .press_count (count2)
  );

  // Clock and reset
  always #5 clock = ~clock;

  task automatic do_reset();
    reset_n = 1'b0;
    in1 = 1'b0;
    in2 = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  // Drivers
  task automatic step(input logic a, input logic b);
    @(negedge clock);
    in1 = a;
    in2 = b;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [10:0] pk(input logic l, input logic r, input logic f,
                                     input logic [7:0] c);
    return {l, r, f, c};
  endfunction

  task automatic add(input logic i, input logic l, input logic r, input logic f,
                     input logic [7:0] c);
    vec_t v;
    v.in_val = i; v.exp_level = l; v.exp_rise = r; v.exp_fall = f; v.exp_count = c;
    vecs.push_back(v);
  endtask

  // Scoreboard
  task automatic check(input string name, input logic [10:0] act);
    logic [10:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual lvl/rise/fall/cnt=%b/%b/%b/%0d expected=%b/%b/%b/%0d",
               name, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Strobes of one instance must never coincide.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      checks++;
      if ((rise1 && fall1) || (rise2 && fall2)) begin
        errors++;
        $display("FAIL strobe_overlap actual rise1/fall1/rise2/fall2=%b%b%b%b expected no pair high",
                 rise1, fall1, rise2, fall2);
      end
    end
  end

  initial begin
    // Clean press: rise on the 4th sampling edge, strobe one cycle.
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 1);
    add(1, 1, 0, 0, 1); add(1, 1, 0, 0, 1);
    // Release
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1);
    // Bounce 1,1,1,0,1,1,1,1
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 2);
    // Release with a contrary sample: 0,0,1,0,0,0,0
    add(0, 1, 0, 0, 2); add(0, 1, 0, 0, 2); add(1, 1, 0, 0, 2);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 2);
    add(0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 2);

    do_reset();
    #1;
    exp_q.push_back(pk(0, 0, 0, 8'd0));
    check("reset_dut1", {level1, rise1, fall1, count1});
    exp_q.push_back(pk(0, 0, 0, 8'd0));
    check("reset_dut2", {level2, rise2, fall2, count2});

    foreach (vecs[i]) begin
      exp_q.push_back(pk(vecs[i].exp_level, vecs[i].exp_rise, vecs[i].exp_fall,
                         vecs[i].exp_count));
      step(vecs[i].in_val, 1'b0);
      check($sformatf("vec%0d", i), {level1, rise1, fall1, count1});
    end

    // Reset between edges during qualification discards the partial count.
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(pk(0, 0, 0, 8'd2));
      step(1'b1, 1'b0);
      check("pre_reset_high", {level1, rise1, fall1, count1});
    end
    #3 reset_n = 1'b0;
    #1;
    exp_q.push_back(pk(0, 0, 0, 8'd0));
    check("async_reset_immediate", {level1, rise1, fall1, count1});
    @(posedge clock);
    #2 reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(k == 4 ? pk(1, 1, 0, 8'd1) : pk(0, 0, 0, 8'd0));
      step(1'b1, 1'b0);
      check($sformatf("post_reset_edge%0d", k), {level1, rise1, fall1, count1});
    end

    // Wrap: 256 clean presses from a fresh reset.
    do_reset();
    for (int p = 1; p <= 256; p++) begin
      logic [7:0] c;
      c = 8'(p);
      for (int k = 1; k <= 4; k++) begin
        step(1'b1, 1'b0);
        if (k == 3) begin
          exp_q.push_back(pk(0, 0, 0, 8'(p - 1)));
          check("wrap_pre_rise", {level1, rise1, fall1, count1});
        end
      end
      exp_q.push_back(pk(1, 1, 0, c));
      check(p == 255 ? "wrap_255" : (p == 256 ? "wrap_0" : "wrap_rise"),
            {level1, rise1, fall1, count1});
      for (int k = 1; k <= 4; k++) step(1'b0, 1'b0);
      exp_q.push_back(pk(0, 0, 1, c));
      check("wrap_fall", {level1, rise1, fall1, count1});
    end

    // Minimum parameter instance.
    do_reset();
    begin
      logic [3:0] alt;
      alt = 4'b1010;
      for (int k = 3; k >= 0; k--) begin
        exp_q.push_back(pk(0, 0, 0, 8'd0));
        step(1'b0, alt[k]);
        check($sformatf("min_alt%0d", 3 - k), {level2, rise2, fall2, count2});
      end
    end
    exp_q.push_back(pk(0, 0, 0, 8'd0));
    step(1'b0, 1'b1);
    check("min_rise_edge1", {level2, rise2, fall2, count2});
    exp_q.push_back(pk(1, 1, 0, 8'd1));
    step(1'b0, 1'b1);
    check("min_rise_edge2", {level2, rise2, fall2, count2});
    exp_q.push_back(pk(1, 0, 0, 8'd1));
    step(1'b0, 1'b0);
    check("min_fall_edge1", {level2, rise2, fall2, count2});
    exp_q.push_back(pk(0, 0, 1, 8'd1));
    step(1'b0, 1'b0);
    check("min_fall_edge2", {level2, rise2, fall2, count2});

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: number of consecutive identical input samples required to accept a level change; legal range 2..65535.
REQ-002 SHALL have localparam CNT_WIDTH = $clog2(DEBOUNCE_CYCLES)+1, the stability counter width.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_sync, input, 1 bit: raw mechanical level, already synchronized to clock.
REQ-006 SHALL have port out_level, output, 1 bit: debounced level, registered.
REQ-007 SHALL have port rise_pulse, output, 1 bit: one-cycle strobe on accepted 0->1 change, registered.
REQ-008 SHALL have port fall_pulse, output, 1 bit: one-cycle strobe on accepted 1->0 change, registered.
REQ-009 SHALL have port press_count, output, 8 bits: count of accepted rises, registered.

Function
REQ-010 SHALL implement FSM states IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
REQ-011 IDLE_LOW: in_sync=1 -> WAIT_HIGH with counter=1; otherwise stay, counter=0.
REQ-012 WAIT_HIGH: in_sync=0 -> IDLE_LOW, counter=0 (bounce rejected, no output change).
REQ-013 WAIT_HIGH: in_sync=1 and counter<DEBOUNCE_CYCLES-1 -> stay, counter+1.
REQ-014 WAIT_HIGH: in_sync=1 and counter=DEBOUNCE_CYCLES-1 -> IDLE_HIGH, counter=0; on this same edge out_level<=1, rise_pulse<=1, press_count<=press_count+1.
REQ-015 IDLE_HIGH/WAIT_LOW SHALL mirror REQ-011..014 with inverted in_sync sense; acceptance sets out_level<=0, fall_pulse<=1; press_count unchanged.
REQ-016 Latency: out_level SHALL change on the clock edge that samples the DEBOUNCE_CYCLES-th consecutive new-level value of in_sync.
REQ-017 rise_pulse and fall_pulse SHALL each be high for exactly one cycle per accepted change, never simultaneously.
REQ-018 press_count SHALL wrap 255 -> 0 without saturation or flag.
REQ-019 A single-cycle contrary sample during WAIT_* SHALL restart qualification from zero; no partial credit.
REQ-020 out_level SHALL be stable while in WAIT_* states; the counter SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-021 Unreachable state encodings SHALL recover to IDLE_LOW on the next edge, with outputs 0 and counter 0.

Reset
REQ-022 reset_n=0 SHALL immediately force state IDLE_LOW, counter=0, out_level=0, rise_pulse=0, fall_pulse=0, press_count=0, regardless of clock.
REQ-023 Reset asserted mid-WAIT_* SHALL discard the partial count; no pulse SHALL be emitted.
REQ-024 If in_sync=1 at reset release, the block SHALL qualify it as a normal rise: DEBOUNCE_CYCLES samples, then rise_pulse and press_count increment.

Structure
REQ-025 State enum type (debounce_state_t) SHALL reside in shared package debounce_pkg, together with the default DEBOUNCE_CYCLES constant.
REQ-026 Single module, no sub-module; counter and FSM inline; one sequential block plus one combinational next-state block.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Clean press: in_sync 0->1 held 6 cycles -> out_level=1 on 4th sampling edge, rise_pulse high exactly 1 cycle, press_count 0->1.
REQ-028 Bounce: in_sync pattern 1,1,1,0,1,1,1,1 -> no change through the 0; out_level rises on the 4th 1 after the 0; exactly one rise_pulse.
REQ-029 Release: from out_level=1, in_sync=0 held 4 cycles -> out_level=0 on 4th edge, fall_pulse 1 cycle, press_count unchanged.
REQ-030 Wrap: 256 clean presses -> press_count reads 255 after the 255th, 0 after the 256th.
REQ-031 Reset mid-qualification: assert reset_n=0 after 2 high samples, asynchronously between edges -> all outputs 0 immediately; after release with in_sync=1, rise occurs 4 edges later.
REQ-032 Minimum parameter: DEBOUNCE_CYCLES=2, alternating 1,0,1,0 -> no output change; 1,1 -> rise on 2nd edge.
